// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the EX-stage multiply/divide units.
//
// Accepts a MULT/MULTU/DIV/DIVU from EX decode and latches the operands and
// signedness. It then either waits out the fixed multiplier latency or runs
// the iterative divider until it reports ready. The 64-bit result is held
// with hilo_we asserted until the pipeline lets EX advance. A flush aborts
// the operation at any point and annuls a running divide.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    abort current operation (exception/eret)
//   ex_hold                  downstream stall, EX instruction stays put
//   op_mult/multu/div/divu   operation present in EX (div>divu>mult>multu)
//   rs_data, rt_data         operands (dividend/multiplicand, divisor/multiplier)
//   mul_signed/ina/inb       to multiplier; mul_result {hi,lo} from it
//   div_signed/op1/op2       to divider; div_start, div_annul control it
//   div_result, div_ready    {remainder,quotient} and valid from divider
//   stallreq_for_ex          stall request while the operation is in flight
//   hilo_we, hi_o, lo_o      HI/LO write port
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        div_start,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq_for_ex,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        op1_reg, op1_next;
    logic [31:0]        op2_reg, op2_next;
    logic               sign_reg, sign_next;
    logic [63:0]        result_reg, result_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            sign_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op1_reg    <= op1_next;
            op2_reg    <= op2_next;
            sign_reg   <= sign_next;
            result_reg <= result_next;
        end
    end

    // Operands come straight from the latched registers so the units see
    // stable inputs for the whole operation; signedness is only presented
    // to the unit that is actually running.
    assign mul_ina    = op1_reg;
    assign mul_inb    = op2_reg;
    assign div_op1    = op1_reg;
    assign div_op2    = op2_reg;
    assign mul_signed = sign_reg && (state_reg == MUL_WAIT);
    assign div_signed = sign_reg && (state_reg == DIV_WAIT);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        op1_next        = op1_reg;
        op2_next        = op2_reg;
        sign_next       = sign_reg;
        result_next     = result_reg;
        stallreq_for_ex = 1'b0;
        hilo_we         = 1'b0;
        div_start       = 1'b0;
        div_annul       = 1'b0;
        hi_o            = '0;
        lo_o            = '0;

        if (flush) begin
            // Flush beats ex_hold, div_ready and the multiply terminal count.
            state_next = IDLE;
            cnt_next   = '0;
            div_annul  = (state_reg == DIV_WAIT);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_div || op_divu || op_mult || op_multu) begin
                        stallreq_for_ex = 1'b1;
                        op1_next        = rs_data;
                        op2_next        = rt_data;
                        cnt_next        = '0;
                        if (op_div || op_divu) begin
                            state_next = DIV_WAIT;
                            sign_next  = op_div;
                        end else begin
                            state_next = MUL_WAIT;
                            sign_next  = op_mult;
                        end
                    end
                end
                MUL_WAIT: begin
                    stallreq_for_ex = 1'b1;
                    cnt_next        = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(MUL_LAT - 1)) begin
                        result_next = mul_result;
                        state_next  = DONE;
                        cnt_next    = '0;
                    end
                end
                DIV_WAIT: begin
                    stallreq_for_ex = 1'b1;
                    if (div_ready) begin
                        result_next = div_result;
                        state_next  = DONE;
                    end else begin
                        div_start = 1'b1;
                    end
                end
                DONE: begin
                    // The op_* still present here belongs to the finished
                    // instruction, so it is deliberately ignored.
                    hilo_we = 1'b1;
                    hi_o    = result_reg[63:32];
                    lo_o    = result_reg[31:0];
                    if (!ex_hold) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed cases with literal expectations plus
// randomized operation streams checked every cycle against a behavioural
// model of the sequencer.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_hold = 1'b0;
    logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        mul_signed, div_signed, div_start, div_annul, div_ready;
    logic [31:0] mul_ina, mul_inb, div_op1, div_op2, hi_o, lo_o;
    logic [63:0] mul_result, div_result;
    logic        stallreq_for_ex, hilo_we;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
        .rs_data(rs_data), .rt_data(rt_data),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result),
        .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
        .div_start(div_start), .div_annul(div_annul),
        .div_result(div_result), .div_ready(div_ready),
        .stallreq_for_ex(stallreq_for_ex), .hilo_we(hilo_we),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // ---------------- arithmetic reference ----------------
    function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // {remainder, quotient}; a zero divisor yields an arbitrary fixed pattern.
    function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'hDEAD_BEEF_0BAD_F00D;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // ---------------- unit models ----------------
    // Multiplier: result valid MUL_LAT-1 clock edges after inputs are applied.
    logic [63:0] mpipe [0:7];
    always @(posedge clk) begin
        mpipe[0] <= mul_fn(mul_ina, mul_inb, mul_signed);
        for (int k = 1; k < 8; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = (MUL_LAT == 1) ? mul_fn(mul_ina, mul_inb, mul_signed)
                                       : mpipe[MUL_LAT-2];

    // Divider: ready after div_lat cycles of div_start.
    int div_lat = 33;
    int dcnt = 0;
    always @(posedge clk) begin
        if (rst || div_annul || div_ready) dcnt <= 0;
        else if (div_start) dcnt <= dcnt + 1;
    end
    assign div_ready  = (dcnt == div_lat);
    assign div_result = div_fn(div_op1, div_op2, div_signed);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // m_kind: 0 nothing in flight, 1 multiply, 2 divide.
    int          m_kind = 0;
    int          m_age  = 0;
    bit          m_done = 0;
    logic [31:0] m_a = '0, m_b = '0;
    bit          m_sgn = 0;
    logic [63:0] m_res = '0;

    always @(negedge clk) begin
        bit          e_stall, e_we, e_start, e_annul, e_msgn, e_dsgn;
        logic [63:0] e_hilo;
        if (rst) begin
            m_kind = 0; m_done = 0; m_age = 0; m_a = '0; m_b = '0; m_sgn = 0; m_res = '0;
        end else begin
            e_stall = 0; e_we = 0; e_start = 0; e_annul = 0; e_msgn = 0; e_dsgn = 0;
            e_hilo = '0;
            if (flush) begin
                e_annul = (m_kind == 2) && !m_done;
                m_kind = 0; m_done = 0;
            end else if (m_kind == 0) begin
                if (op_div || op_divu || op_mult || op_multu) begin
                    e_stall = 1;
                    m_a = rs_data; m_b = rt_data; m_age = 0; m_done = 0;
                    if (op_div)       begin m_kind = 2; m_sgn = 1; end
                    else if (op_divu) begin m_kind = 2; m_sgn = 0; end
                    else if (op_mult) begin m_kind = 1; m_sgn = 1; end
                    else              begin m_kind = 1; m_sgn = 0; end
                end
            end else if (m_done) begin
                e_we = 1; e_hilo = m_res;
                if (!ex_hold) begin m_kind = 0; m_done = 0; end
            end else if (m_kind == 1) begin
                e_stall = 1; e_msgn = m_sgn;
                chk("mul_ina", {32'b0, mul_ina}, {32'b0, m_a});
                chk("mul_inb", {32'b0, mul_inb}, {32'b0, m_b});
                if (m_age == MUL_LAT - 1) begin
                    m_res = mul_fn(m_a, m_b, m_sgn); m_done = 1;
                end
                m_age++;
            end else begin
                e_stall = 1; e_dsgn = m_sgn; e_start = !div_ready;
                chk("div_op1", {32'b0, div_op1}, {32'b0, m_a});
                chk("div_op2", {32'b0, div_op2}, {32'b0, m_b});
                if (div_ready) begin
                    m_res = div_fn(m_a, m_b, m_sgn); m_done = 1;
                end
            end
            chk("stallreq", {63'b0, stallreq_for_ex}, {63'b0, e_stall});
            chk("hilo_we",  {63'b0, hilo_we},         {63'b0, e_we});
            chk("hilo",     {hi_o, lo_o},             e_hilo);
            chk("div_start",{63'b0, div_start},       {63'b0, e_start});
            chk("div_annul",{63'b0, div_annul},       {63'b0, e_annul});
            if (!flush) begin
                chk("mul_signed", {63'b0, mul_signed}, {63'b0, e_msgn});
                chk("div_signed", {63'b0, div_signed}, {63'b0, e_dsgn});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            {op_div, op_divu, op_mult, op_multu} = 4'b0;
            flush = 0; rst = 0;
            ex_hold = 1'($urandom_range(0, 1));
        end
    endtask

    // ops = {div, divu, mult, multu}; abort_at = cycle index of flush/rst (-1 none).
    task automatic run_op(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int abort_at, input bit abort_rst,
                          output int n_stall, output int n_we, output int n_start,
                          output int n_annul, output logic [31:0] hi, output logic [31:0] lo);
        bit fin = 0;
        n_stall = 0; n_we = 0; n_start = 0; n_annul = 0; hi = '0; lo = '0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            {op_div, op_divu, op_mult, op_multu} = ops;
            rs_data = a; rt_data = b;
            ex_hold = (n_we < hold);
            flush = (i == abort_at) && !abort_rst;
            rst   = (i == abort_at) && abort_rst;
            @(negedge clk);
            if (stallreq_for_ex) n_stall++;
            if (div_start) n_start++;
            if (div_annul) n_annul++;
            if (hilo_we) begin n_we++; hi = hi_o; lo = lo_o; end
            if (i == abort_at || (hilo_we && !ex_hold)) begin fin = 1; break; end
        end
        if (!fin) begin
            n_checks++;
            $display("FAIL timeout: op %b did not complete within 300 cycles", ops);
        end
        $display("op=%b a=0x%08h b=0x%08h hold=%0d abort=%0d stall=%0d we=%0d start=%0d annul=%0d hi=0x%08h lo=0x%08h",
                 ops, a, b, hold, abort_at, n_stall, n_we, n_start, n_annul, hi, lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ns, nw, nst, nan;
        logic [31:0] hi, lo;
        logic [3:0]  ops;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_outputs",
            {32'b0, stallreq_for_ex, hilo_we, div_start, div_annul, mul_signed, div_signed, 26'b0},
            64'b0);
        chk("reset_hilo", {hi_o, lo_o}, 64'b0);

        // multu 0xFFFFFFFF * 2
        run_op(4'b0001, 32'hFFFF_FFFF, 32'd2, 0, -1, 0, ns, nw, nst, nan, hi, lo);
        chk("multu_stall_cycles", 64'(ns), 64'(MUL_LAT + 1));
        chk("multu_we_cycles", 64'(nw), 64'd1);
        chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // mult -3 * 5, back-to-back with the previous op
        run_op(4'b0010, 32'hFFFF_FFFD, 32'd5, 0, -1, 0, ns, nw, nst, nan, hi, lo);
        chk("mult_we_cycles", 64'(nw), 64'd1);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // div -7 / 2 with a 33-cycle divider
        div_lat = 33;
        run_op(4'b1000, 32'hFFFF_FFF9, 32'd2, 0, -1, 0, ns, nw, nst, nan, hi, lo);
        chk("div_start_cycles", 64'(nst), 64'd33);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // divu flushed in DIV_WAIT
        run_op(4'b0100, 32'd1000, 32'd3, 0, 10, 0, ns, nw, nst, nan, hi, lo);
        chk("flush_annul_cycles", 64'(nan), 64'd1);
        chk("flush_no_we", 64'(nw), 64'd0);
        chk("flush_stall_cycles", 64'(ns), 64'd10);
        idle(1);

        // multu held in DONE for 4 cycles
        run_op(4'b0001, 32'd7, 32'd9, 4, -1, 0, ns, nw, nst, nan, hi, lo);
        chk("hold_we_cycles", 64'(nw), 64'd5);
        chk("hold_stall_cycles", 64'(ns), 64'(MUL_LAT + 1));
        chk("hold_hilo", {hi, lo}, 64'd63);
        idle(2);

        // reset mid DIV_WAIT, then a fresh mult
        div_lat = 20;
        run_op(4'b1000, 32'd50, 32'd7, 0, 5, 1, ns, nw, nst, nan, hi, lo);
        run_op(4'b0010, 32'd6, 32'hFFFF_FFF9, 0, -1, 0, ns, nw, nst, nan, hi, lo);
        chk("post_reset_mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

        // several op_* high: div wins over mult, divu wins over multu
        div_lat = 3;
        run_op(4'b1010, 32'd100, 32'd7, 0, -1, 0, ns, nw, nst, nan, hi, lo);
        chk("prio_div_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
        run_op(4'b0101, 32'hFFFF_FFF0, 32'd16, 0, -1, 0, ns, nw, nst, nan, hi, lo);
        chk("prio_divu_hilo", {hi, lo}, 64'h0000_0000_0FFF_FFFF);

        // randomized streams, checked by the per-cycle model
        for (int t = 0; t < 150; t++) begin
            int ab;
            if ($urandom_range(0, 4) == 0) ops = 4'($urandom_range(1, 15));
            else ops = 4'b0001 << $urandom_range(0, 3);
            div_lat = $urandom_range(1, 40);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : -1;
            run_op(ops, pick_operand(), pick_operand(), $urandom_range(0, 3), ab,
                   ($urandom_range(0, 9) == 0), ns, nw, nst, nan, hi, lo);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
